muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Multi-cycle sequencer for the ALU_MUL..ALU_MODU operations of the execute stage.
- Accepts one operation at a time from EX and drives a pipelined multiplier and a radix-2 iterative divider.
- Holds the result until EX consumes it; stalls the pipeline while busy.
- All other AluCtrl codes stay in the single-cycle ALU.

Parameters:
- MUL_LAT, 2, cycles spent in MUL state (legal 1..4); models the registered multiplier pipeline.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; aborts any operation
- req_valid  in  1  operation request
- req_ready  out  1  request accepted when req_valid & req_ready
- req_op  in  5  AluCtrl code
- req_src1  in  32  DType rj operand
- req_src2  in  32  DType rk operand
- resp_valid  out  1  result available
- resp_ready  in  1  EX consumes result
- resp_data  out  32  DType result
- busy  out  1  operation in flight (stall request to pipeline)

Behaviour:
- Interface: one clock clk; reset rst, synchronous, active-high.
- Reset: state IDLE; resp_valid=0, resp_data=0, busy=0. req_ready=1 in the first cycle after reset.
- req_ready = (state==IDLE) & !flush, combinational.
- Acceptance: only when req_op is in ALU_MUL..ALU_MODU. Other codes: no state change, no response.
- FSM states: IDLE, MUL, PREP, DIV, DONE.
  - IDLE: on accept with a mul op go to MUL with cnt=MUL_LAT-1; with a div op go to PREP. Operands and op are latched.
  - MUL: decrement cnt; at 0 go to DONE with the product selected:
    - MUL: low 32 bits.
    - MULH: signed x signed, high 32 bits.
    - MULHU: unsigned, high 32 bits.
  - PREP: latch absolute values (signed ops) and result signs; cnt=31; go to DIV.
  - DIV: one restoring step per cycle, MSB first; at cnt==0 apply sign fix and go to DONE.
  - DONE: resp_valid=1 and resp_data held stable; on resp_ready go to IDLE.
- Latency: accept in cycle t → resp_valid in cycle t+1+MUL_LAT for mul ops, t+34 for div ops.
- busy=1 in every state except IDLE.
- Sign rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero: quotient = 0xFFFFFFFF; remainder = dividend. Uses the normal iteration count.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; MOD → 0.
- flush:
  - Any state goes to IDLE next cycle; resp_valid=0 next cycle.
  - A request presented in the same cycle is not accepted.
  - flush overrides resp_ready.
- No back-to-back acceptance; a new request is accepted only once the FSM is back in IDLE.
- rst mid-operation: abandons immediately, same result as reset.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: a div op goes from IDLE directly to DONE (resp_valid at t+1) when either holds:
  - divisor==0: results per the divide-by-zero rule.
  - |dividend| < |divisor| in the op's signedness: quotient 0, remainder = dividend.
- Undefined: all div ops take 34 cycles.

Decomposition:
- Additions to the shared cpuDefine package:
  - MdState enum {MD_IDLE, MD_MUL, MD_PREP, MD_DIV, MD_DONE}.
  - DIV_ITER = 32.
  - Function isMulDiv(AluCtrl).
- AluCtrl and DType are reused from the same package.
- One sub-module: muldiv_div_core. Holds the iterative divider datapath: remainder/quotient registers, step, sign fix. Controlled by load/step enables from the FSM.

Test Plan:
- MUL_LAT=2, MUL 0x00000003 × 0xFFFFFFFE → 0xFFFFFFFA at t+3. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000.
- Signed and unsigned divide, responses at t+34:
  - DIV −7/2 → 0xFFFFFFFD; MOD −7/2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC; MODU → 0x00000001.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF; MOD 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; MOD → 0.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE → resp_valid=1, resp_data stable, req_ready=0, busy=1. Release → IDLE next cycle.
- Abort: flush at t+10 of a DIV → resp_valid never asserts; req_ready=1 at t+11. A following MUL 4×5 → 20 at normal latency. Repeat with rst instead of flush → same outcome.
- Early-out: DIVU 3/10 → 0 and MODU 3/10 → 3. With MULDIV_EARLY_OUT_EN the response arrives at t+1; without it, at t+34. A non-muldiv op (ALU_ADD) with req_valid produces no response and no busy.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and helpers for the execute-stage multiply/divide sequencer.
// AluCtrl and DType are the common ALU encodings; MdState, DIV_ITER and the
// op-class helpers belong to the multi-cycle muldiv path.
package muldiv_ctrl_pkg;

  typedef logic [31:0] DType;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_SLT   = 5'd2,
    ALU_SLTU  = 5'd3,
    ALU_AND   = 5'd4,
    ALU_OR    = 5'd5,
    ALU_XOR   = 5'd6,
    ALU_NOR   = 5'd7,
    ALU_SLL   = 5'd8,
    ALU_SRL   = 5'd9,
    ALU_SRA   = 5'd10,
    ALU_LUI   = 5'd11,
    ALU_MUL   = 5'd12,
    ALU_MULH  = 5'd13,
    ALU_MULHU = 5'd14,
    ALU_DIV   = 5'd15,
    ALU_MOD   = 5'd16,
    ALU_DIVU  = 5'd17,
    ALU_MODU  = 5'd18
  } AluCtrl;

  typedef enum logic [2:0] {
    MD_IDLE,
    MD_MUL,
    MD_PREP,
    MD_DIV,
    MD_DONE
  } MdState;

  localparam int DIV_ITER = 32;

  // True for every code handled by the multi-cycle unit
  function automatic logic isMulDiv(AluCtrl op);
    return (op >= ALU_MUL) && (op <= ALU_MODU);
  endfunction

  // True for the four divider codes
  function automatic logic isDivOp(AluCtrl op);
    return (op >= ALU_DIV) && (op <= ALU_MODU);
  endfunction

  // Signed divider codes
  function automatic logic isSignedDiv(AluCtrl op);
    return (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

  // Codes that return the remainder rather than the quotient
  function automatic logic isRemOp(AluCtrl op);
    return (op == ALU_MOD) || (op == ALU_MODU);
  endfunction

  // Absolute value when the operand is treated as signed; 0x80000000 maps
  // to itself, which is the correct unsigned magnitude 2^31
  function automatic DType magnitude(DType v, logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/response handshake between EX (master) and the muldiv sequencer
// (slave). flush rides along with the handshake since it aborts it.
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  logic   flush;
  logic   req_valid;
  logic   req_ready;
  AluCtrl req_op;
  DType   req_src1;
  DType   req_src2;
  logic   resp_valid;
  logic   resp_ready;
  DType   resp_data;
  logic   busy;

  modport master (
    output flush, req_valid, req_op, req_src1, req_src2, resp_ready,
    input  req_ready, resp_valid, resp_data, busy
  );

  modport slave (
    input  flush, req_valid, req_op, req_src1, req_src2, resp_ready,
    output req_ready, resp_valid, resp_data, busy
  );

endinterface

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divider datapath. load captures operand magnitudes and
// result signs; each step retires one quotient bit, MSB first. The sign-fixed
// outputs reflect the values after the step in progress, so the controller
// can capture the final result on the same edge as the last step.
module muldiv_div_core
  import muldiv_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic step,
  input  logic is_signed,
  input  DType dividend,
  input  DType divisor,
  output DType quo_fixed,
  output DType rem_fixed
);

  DType        rem_q;
  DType        quo_q;
  DType        dvs_q;
  logic        q_neg;
  logic        r_neg;
  logic [32:0] partial;
  logic [32:0] diff;
  DType        rem_next;
  DType        quo_next;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    partial  = {rem_q, quo_q[31]};
    diff     = partial - {1'b0, dvs_q};
    rem_next = partial[31:0];
    quo_next = {quo_q[30:0], 1'b0};
    if (!diff[32]) begin
      rem_next = diff[31:0];
      quo_next = {quo_q[30:0], 1'b1};
    end
    quo_fixed = q_neg ? (~quo_next + 32'd1) : quo_next;
    rem_fixed = r_neg ? (~rem_next + 32'd1) : rem_next;
  end

  // Operand capture and iteration registers; a zero divisor keeps the
  // all-ones quotient unsigned so divide-by-zero yields 0xFFFFFFFF
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= magnitude(dividend, is_signed);
      dvs_q <= magnitude(divisor, is_signed);
      q_neg <= is_signed && (dividend[31] ^ divisor[31]) && (divisor != '0);
      r_neg <= is_signed && dividend[31];
    end else if (step) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle sequencer for ALU_MUL..ALU_MODU. Accepts one operation at a
// time, runs the multiplier for MUL_LAT cycles or the iterative divider for
// 34 cycles, then holds the result until EX takes it.
// Optional macro MULDIV_EARLY_OUT_EN: divides by zero or with |dividend| <
// |divisor| finish straight from IDLE with resp_valid one cycle later.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  bus
);

  localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_LAT - 1);
  localparam logic [4:0] DIV_CNT_INIT = 5'(DIV_ITER - 1);

  MdState      state;
  logic [4:0]  cnt;
  AluCtrl      op_q;
  DType        src1_q;
  DType        src2_q;
  logic        resp_valid_q;
  DType        resp_data_q;
  logic        busy_q;

  logic        accept;
  logic        mul_signed;
  logic [63:0] prod;
  DType        mul_result;
  DType        quo_fixed;
  DType        rem_fixed;
  DType        div_result;
  logic        early_hit;
  DType        early_data;

  assign bus.req_ready  = (state == MD_IDLE) && !bus.flush;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.busy       = busy_q;

  assign accept = bus.req_valid && bus.req_ready && isMulDiv(bus.req_op);

  // Single multiplier; only MULH needs sign extension, the low word is the
  // same for either extension
  always_comb begin
    mul_signed = (op_q == ALU_MULH);
    prod = {{32{mul_signed & src1_q[31]}}, src1_q} *
           {{32{mul_signed & src2_q[31]}}, src2_q};
    if (op_q == ALU_MUL) mul_result = prod[31:0];
    else                 mul_result = prod[63:32];
    div_result = isRemOp(op_q) ? rem_fixed : quo_fixed;
  end

`ifdef MULDIV_EARLY_OUT_EN
  // Trivial divides resolved from the incoming request; in both cases the
  // remainder equals the dividend
  always_comb begin
    early_hit = (bus.req_src2 == '0) ||
                (magnitude(bus.req_src1, isSignedDiv(bus.req_op)) <
                 magnitude(bus.req_src2, isSignedDiv(bus.req_op)));
    if (isRemOp(bus.req_op))       early_data = bus.req_src1;
    else if (bus.req_src2 == '0)   early_data = 32'hFFFF_FFFF;
    else                           early_data = '0;
  end
`else
  assign early_hit  = 1'b0;
  assign early_data = '0;
`endif

  muldiv_div_core u_div_core (
    .clk       (clk),
    .rst       (rst),
    .load      (state == MD_PREP),
    .step      (state == MD_DIV),
    .is_signed (isSignedDiv(op_q)),
    .dividend  (src1_q),
    .divisor   (src2_q),
    .quo_fixed (quo_fixed),
    .rem_fixed (rem_fixed)
  );

  // Sequencer FSM with registered response and stall outputs; flush wins
  // over everything except reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= MD_IDLE;
      cnt          <= '0;
      op_q         <= ALU_ADD;
      src1_q       <= '0;
      src2_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      busy_q       <= 1'b0;
    end else if (bus.flush) begin
      state        <= MD_IDLE;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (accept) begin
            op_q   <= bus.req_op;
            src1_q <= bus.req_src1;
            src2_q <= bus.req_src2;
            busy_q <= 1'b1;
            if (!isDivOp(bus.req_op)) begin
              state <= MD_MUL;
              cnt   <= MUL_CNT_INIT;
            end else if (early_hit) begin
              state        <= MD_DONE;
              resp_valid_q <= 1'b1;
              resp_data_q  <= early_data;
            end else begin
              state <= MD_PREP;
            end
          end
        end
        MD_MUL: begin
          if (cnt == '0) begin
            state        <= MD_DONE;
            resp_valid_q <= 1'b1;
            resp_data_q  <= mul_result;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        MD_PREP: begin
          state <= MD_DIV;
          cnt   <= DIV_CNT_INIT;
        end
        MD_DIV: begin
          if (cnt == '0) begin
            state        <= MD_DONE;
            resp_valid_q <= 1'b1;
            resp_data_q  <= div_result;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        MD_DONE: begin
          if (bus.resp_ready) begin
            state        <= MD_IDLE;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state        <= MD_IDLE;
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus randomized
// operations compared against an arithmetic reference model. Honours
// MULDIV_EARLY_OUT_EN when computing expected latency.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int MUL_LAT = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  muldiv_ctrl_if bus ();

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected result from plain signed/unsigned arithmetic
  function automatic DType ref_result(AluCtrl op, DType a, DType b);
    longint          sa;
    longint          sb;
    longint          p;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned pu;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      ALU_MUL:   begin pu = ua * ub; return pu[31:0]; end
      ALU_MULH:  begin p = sa * sb;  return p[63:32]; end
      ALU_MULHU: begin pu = ua * ub; return pu[63:32]; end
      ALU_DIV:   begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      ALU_MOD:   begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      ALU_DIVU:  begin if (b == 0) return 32'hFFFF_FFFF; pu = ua / ub; return pu[31:0]; end
      ALU_MODU:  begin if (b == 0) return a; pu = ua % ub; return pu[31:0]; end
      default:   return 32'h0;
    endcase
  endfunction

  // Expected cycles from acceptance to resp_valid
  function automatic int ref_latency(AluCtrl op, DType a, DType b);
    longint ma;
    longint mb;
    if (op == ALU_MUL || op == ALU_MULH || op == ALU_MULHU) return 1 + MUL_LAT;
    if (op == ALU_DIV || op == ALU_MOD) begin
      ma = $signed(a);
      mb = $signed(b);
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
    end else begin
      ma = {32'd0, a};
      mb = {32'd0, b};
    end
`ifdef MULDIV_EARLY_OUT_EN
    if (mb == 0 || ma < mb) return 1;
`endif
    if (ma < 0) return 0;
    return 34;
  endfunction

  // Issue one operation, measure latency, capture result, consume it
  task automatic run_op(input AluCtrl op, input DType a, input DType b,
                        output DType data, output int lat);
    int guard;
    @(negedge clk);
    bus.req_op    = op;
    bus.req_src1  = a;
    bus.req_src2  = b;
    bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat  = -1;
    data = 32'hDEAD_BEEF;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) begin
        lat  = k;
        data = bus.resp_data;
        break;
      end
    end
    if (lat > 0) begin
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1 bus.resp_ready = 1'b0;
    end
  endtask

  // Reset values and readiness right after reset
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid got %b want 0", bus.resp_valid); end
    checks++;
    if (bus.resp_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_resp_data got %h want 00000000", bus.resp_data); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got %b want 1", bus.req_ready); end
  endtask

  // Multiplier variants with known products
  task automatic test_mul();
    AluCtrl ops[3] = '{ALU_MUL, ALU_MULHU, ALU_MULH};
    DType   as[3]  = '{32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    DType   bs[3]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    DType   exp[3] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'h0};
    DType   data;
    int     lat;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], as[i], bs[i], data, lat);
      checks++;
      if (data !== exp[i]) begin errors++; $display("[TB] FAIL mul_%s data got %h want %h", ops[i].name(), data, exp[i]); end
      checks++;
      if (lat != 1 + MUL_LAT) begin errors++; $display("[TB] FAIL mul_%s latency got %0d want %0d", ops[i].name(), lat, 1 + MUL_LAT); end
    end
  endtask

  // Signed/unsigned divide, divide-by-zero and overflow
  task automatic test_div();
    AluCtrl ops[8] = '{ALU_DIV, ALU_MOD, ALU_DIVU, ALU_MODU, ALU_DIV, ALU_MOD, ALU_DIV, ALU_MOD};
    DType   as[8]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                       32'h5, 32'h5, 32'h8000_0000, 32'h8000_0000};
    DType   bs[8]  = '{32'h2, 32'h2, 32'h2, 32'h2, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    DType   exp[8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h1,
                       32'hFFFF_FFFF, 32'h5, 32'h8000_0000, 32'h0};
    DType   data;
    int     lat;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], data, lat);
      checks++;
      if (data !== exp[i]) begin errors++; $display("[TB] FAIL div_%0d_%s data got %h want %h", i, ops[i].name(), data, exp[i]); end
      checks++;
      if (lat != ref_latency(ops[i], as[i], bs[i])) begin
        errors++; $display("[TB] FAIL div_%0d_%s latency got %0d want %0d", i, ops[i].name(), lat, ref_latency(ops[i], as[i], bs[i]));
      end
    end
  endtask

  // Result held under backpressure, then released
  task automatic test_backpressure();
    int seen;
    @(negedge clk);
    bus.req_op = ALU_MUL; bus.req_src1 = 32'd6; bus.req_src2 = 32'd7; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (seen != 1) begin errors++; $display("[TB] FAIL bp_resp_timeout got no resp_valid want resp_valid"); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'd42 || bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_hold_%0d got valid=%b data=%h ready=%b busy=%b want 1 0000002a 0 1",
                 c, bus.resp_valid, bus.resp_data, bus.req_ready, bus.busy);
      end
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release got valid=%b ready=%b busy=%b want 0 1 0", bus.resp_valid, bus.req_ready, bus.busy);
    end
  endtask

  // Abort a divide at t+10 with flush or reset, then run a normal multiply
  task automatic test_abort(input logic use_rst);
    int   seen;
    DType data;
    int   lat;
    @(negedge clk);
    bus.req_op = ALU_DIV; bus.req_src1 = 32'd100; bus.req_src2 = 32'd3; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k < 10; k++) @(negedge clk);
    @(negedge clk);
    if (use_rst) rst = 1'b1;
    else         bus.flush = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_%s_t11 got ready=%b valid=%b busy=%b want 1 0 0",
               use_rst ? "rst" : "flush", bus.req_ready, bus.resp_valid, bus.busy);
    end
    if (use_rst) begin
      checks++;
      if (bus.resp_data !== 32'h0) begin errors++; $display("[TB] FAIL abort_rst_data got %h want 00000000", bus.resp_data); end
    end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("[TB] FAIL abort_%s_no_resp got %0d valid cycles want 0", use_rst ? "rst" : "flush", seen); end
    run_op(ALU_MUL, 32'd4, 32'd5, data, lat);
    checks++;
    if (data !== 32'd20 || lat != 1 + MUL_LAT) begin
      errors++; $display("[TB] FAIL abort_followup_mul got data=%h lat=%0d want 00000014 %0d", data, lat, 1 + MUL_LAT);
    end
    if (!use_rst) begin
      // A request alongside flush in IDLE must not be taken
      @(negedge clk);
      bus.flush = 1'b1; bus.req_op = ALU_MUL; bus.req_src1 = 32'd2; bus.req_src2 = 32'd2; bus.req_valid = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_req_ready got %b want 0", bus.req_ready); end
      @(posedge clk);
      #1 bus.flush = 1'b0; bus.req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_accept busy got %b want 0", bus.busy); end
    end
  endtask

  // Small-dividend divides and a non-muldiv op
  task automatic test_early_out();
    DType data;
    int   lat;
    int   seen;
    run_op(ALU_DIVU, 32'd3, 32'd10, data, lat);
    checks++;
    if (data !== 32'd0 || lat != ref_latency(ALU_DIVU, 32'd3, 32'd10)) begin
      errors++; $display("[TB] FAIL early_divu got data=%h lat=%0d want 00000000 %0d", data, lat, ref_latency(ALU_DIVU, 32'd3, 32'd10));
    end
    run_op(ALU_MODU, 32'd3, 32'd10, data, lat);
    checks++;
    if (data !== 32'd3 || lat != ref_latency(ALU_MODU, 32'd3, 32'd10)) begin
      errors++; $display("[TB] FAIL early_modu got data=%h lat=%0d want 00000003 %0d", data, lat, ref_latency(ALU_MODU, 32'd3, 32'd10));
    end
    @(negedge clk);
    bus.req_op = ALU_ADD; bus.req_src1 = 32'd1; bus.req_src2 = 32'd2; bus.req_valid = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) seen++;
    end
    bus.req_valid = 1'b0;
    checks++;
    if (seen != 0) begin errors++; $display("[TB] FAIL non_muldiv got %0d busy/valid cycles want 0", seen); end
  endtask

  // Randomized operations against the reference model
  task automatic test_random();
    AluCtrl ops[7] = '{ALU_MUL, ALU_MULH, ALU_MULHU, ALU_DIV, ALU_MOD, ALU_DIVU, ALU_MODU};
    AluCtrl op;
    DType   a;
    DType   b;
    DType   data;
    int     lat;
    for (int i = 0; i < 30; i++) begin
      op = ops[$urandom_range(0, 6)];
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF - $urandom_range(0, 7);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) a = $urandom_range(0, 20);
      run_op(op, a, b, data, lat);
      checks++;
      if (data !== ref_result(op, a, b)) begin
        errors++; $display("[TB] FAIL rand_%0d_%s(%h,%h) data got %h want %h", i, op.name(), a, b, data, ref_result(op, a, b));
      end
      checks++;
      if (lat != ref_latency(op, a, b)) begin
        errors++; $display("[TB] FAIL rand_%0d_%s(%h,%h) latency got %0d want %0d", i, op.name(), a, b, lat, ref_latency(op, a, b));
      end
    end
  endtask

  // Test sequence
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op = ALU_ADD;
    bus.req_src1 = '0;
    bus.req_src2 = '0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_backpressure();
    test_abort(1'b0);
    test_abort(1'b1);
    test_early_out();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
